rsc_punct_ser: RTL and testbench
================================

Name: rsc_punct_ser

Overview:
- Downstream stage of the dual-RSC (turbo) encoder.
- Consumes each 4-bit encoder symbol (systematic 1, parity 1, systematic 2, parity 2) together with its valid strobe.
- Punctures the symbol to the selected code rate, buffers it in a small FIFO, and serializes the surviving bits one per clock onto a ready/valid bit stream for the channel/modulator stage.

Parameters:
- DEPTH, 8, FIFO depth in symbols; power of 2, minimum 2.
- AW, 3, log2(DEPTH); fifo_level is AW+1 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- sym_in  in  4  encoder symbol; bit0=sys1, bit1=par1, bit2=sys2, bit3=par2
- sym_valid  in  1  symbol strobe, one symbol per high cycle; no backpressure
- rate_sel  in  2  0 = rate 1/4, 1 = rate 1/3, 2 = rate 1/2, 3 = reserved (treated as 1/4)
- sync_clr  in  1  synchronous clear of the puncture phase and the overflow flag
- ser_ready  in  1  downstream accepts a bit
- ser_out  out  1  serial bit
- ser_valid  out  1  ser_out is valid
- fifo_level  out  AW+1  symbols stored in the FIFO (excludes the shift register)
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset (asynchronous assert, synchronous release) clears:
  - all outputs to 0;
  - FIFO pointers, the puncture phase bit and the shift register;
  - the state machine, to IDLE.
- Mask generation is done at write time. Each accepted symbol is stored as 4 data bits plus a 4-bit keep mask built from rate_sel sampled in the same cycle.
  - Rate 1/4: mask 1111.
  - Rate 1/3: mask 1011, i.e. keep sys1, par1, par2; drop sys2.
  - Rate 1/2: phase 0 gives mask 0011 (sys1, par1); phase 1 gives mask 1001 (sys1, par2).
- Phase bit:
  - Toggles on every accepted symbol, in any rate.
  - sync_clr forces phase to 0 and wins over a simultaneous toggle.
- Write rule:
  - sym_valid with the FIFO not full writes the symbol.
  - Full is evaluated before the edge. If the FIFO is full but a load into the shift register happens on the same edge, the write is accepted.
  - If the FIFO is full and no load happens, the symbol is dropped and ovf is set.
  - ovf stays set until reset or sync_clr. If sync_clr and an overflow occur in the same cycle, ovf stays set.
- State machine:
  - IDLE: ser_valid = 0. If the FIFO is non-empty, pop the head into the shift register and bit pointer, then go to SHIFT.
  - SHIFT: ser_valid = 1 and ser_out = the data bit at the pointer.
  - On a transfer (ser_valid && ser_ready), advance the pointer to the next higher set mask bit.
  - After the last kept bit transfers: if the FIFO is non-empty, pop the next entry on the same edge (no bubble); otherwise go to IDLE.
  - ser_ready low holds ser_out and ser_valid stable.
- Bit order within a symbol is ascending index over the kept bits.
- Latency:
  - Symbol sampled at edge N with the block IDLE and the FIFO empty: first bit valid after edge N+1.
  - Back-to-back symbols with ser_ready held high produce a gapless stream.
- Total buffering is DEPTH+1 symbols: DEPTH in the FIFO plus one in the shift register.
- fifo_level is updated each edge: +1 on write, −1 on pop, unchanged when both occur.
- Pointers wrap modulo DEPTH. An extra MSB on the pointers distinguishes full from empty.
- A rate_sel change affects only symbols written after the change. Queued symbols keep their stored mask.

Optional Feature:
- Macro: RSC_PUNCT_BITCNT_EN.
- When defined:
  - Adds output port bit_count (out, 16 bits).
  - bit_count increments on every ser_valid && ser_ready transfer and wraps at 65535 → 0.
  - It is cleared by reset and by sync_clr; sync_clr wins over a simultaneous increment.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset = 0 with sym_valid toggling → ser_valid, ser_out, fifo_level, ovf all 0; after release, no output until the first symbol is written.
- Rate 1/4: rate_sel = 0, ser_ready = 1, one symbol 4'b1011 at edge N → ser_valid high after edges N+1 through N+4 with ser_out = 1, 1, 0, 1; ser_valid = 0 after edge N+5.
- Rate 1/3 streaming: rate_sel = 1, symbols 4'b1111 and 4'b0100 on consecutive cycles, ser_ready = 1 → bits 1, 1, 1, 0, 0, 0 with no gap; sys2 is never emitted.
- Rate 1/2 phase: sync_clr pulse, then symbols 4'b1010, 4'b1010, 4'b0101 → bits 0, 1 | 0, 1 | 1, 0 (par1, par2, par1 alternate); ser_ready toggling 1-0-1 stretches each bit without loss.
- Overflow (DEPTH = 8): ser_ready = 0, sym_valid high for 10 cycles → first 9 accepted, fifo_level = 8, 10th dropped, ovf = 1; sync_clr → ovf = 0; ser_ready = 1 drains the symbols in order.
- Reset mid-serialization: assert reset during the 2nd bit of a rate-1/4 symbol with 3 queued → outputs 0 immediately (asynchronous); after release, fifo_level = 0 and the phase restarts at 0.

Source files
------------

// File: rtl/rsc_punct_ser.sv
// Turbo-encoder output stage: punctures 4-bit RSC symbols to rate 1/4, 1/3 or 1/2,
// buffers them in a small FIFO and serializes the kept bits onto a ready/valid bit stream.
// Optional: define RSC_PUNCT_BITCNT_EN to add a 16-bit transferred-bit counter output.
module rsc_punct_ser #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    sym_in,
    input  logic          sym_valid,
    input  logic [1:0]    rate_sel,
    input  logic          sync_clr,
    input  logic          ser_ready,
    output logic          ser_out,
    output logic          ser_valid,
    output logic [AW:0]   fifo_level,
    output logic          ovf
`ifdef RSC_PUNCT_BITCNT_EN
    ,
    output logic [15:0]   bit_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
    localparam logic [3:0]  MASK_R14   = 4'b1111;
    localparam logic [3:0]  MASK_R13   = 4'b1011;
    localparam logic [3:0]  MASK_R12_0 = 4'b0011;
    localparam logic [3:0]  MASK_R12_1 = 4'b1001;

    state_t       state_q, state_d;
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]   mem_data [DEPTH];
    logic [3:0]   mem_mask [DEPTH];
    logic [3:0]   data_q, data_d;
    logic [3:0]   mask_q, mask_d;
    logic [1:0]   bptr_q, bptr_d;
    logic         phase_q, phase_d;
    logic         ovf_q, ovf_d;

    logic         empty, full, pop, wr_en, overflow;
    logic [3:0]   head_data, head_mask, wr_mask;
    logic [1:0]   head_first, nxt_ptr;
    logic         has_next;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data  = mem_data[rd_ptr_q[AW-1:0]];
    assign head_mask  = mem_mask[rd_ptr_q[AW-1:0]];
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign ovf        = ovf_q;

    // A pop on this edge frees a slot, so a write to a full FIFO still lands.
    assign wr_en    = sym_valid && (!full || pop);
    assign overflow = sym_valid && full && !pop;

    always_comb begin
        wr_mask = MASK_R14;
        case (rate_sel)
            2'd1:    wr_mask = MASK_R13;
            2'd2:    wr_mask = phase_q ? MASK_R12_1 : MASK_R12_0;
            default: wr_mask = MASK_R14;
        endcase
    end

    // Lowest kept bit of the head entry, and next kept bit above the current pointer.
    always_comb begin
        head_first = 2'd0;
        nxt_ptr    = bptr_q;
        has_next   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (head_mask[i]) begin
                head_first = 2'(i);
            end
            if (mask_q[i] && (i > int'(bptr_q))) begin
                nxt_ptr  = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        bptr_d    = bptr_q;
        pop       = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = head_data;
                    mask_d  = head_mask;
                    bptr_d  = head_first;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = data_q[bptr_q];
                if (ser_ready) begin
                    if (has_next) begin
                        bptr_d = nxt_ptr;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        data_d = head_data;
                        mask_d = head_mask;
                        bptr_d = head_first;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (sync_clr) begin
            phase_d = 1'b0;
        end else if (wr_en) begin
            phase_d = ~phase_q;
        end
        ovf_d = ovf_q;
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (sync_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q[AW-1:0]] <= sym_in;
            mem_mask[wr_ptr_q[AW-1:0]] <= wr_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            bptr_q   <= '0;
            phase_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            bptr_q  <= bptr_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

`ifdef RSC_PUNCT_BITCNT_EN
    logic [15:0] bitcnt_q;

    assign bit_count = bitcnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt_q <= '0;
        end else if (sync_clr) begin
            bitcnt_q <= '0;
        end else if (ser_valid && ser_ready) begin
            bitcnt_q <= bitcnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rsc_punct_ser.sv
// Directed bench for rsc_punct_ser: a scoreboard queue holds the expected serial bits,
// pushed as symbols are driven and popped by a monitor on every accepted transfer.
module tb_rsc_punct_ser;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sym_in;
    logic       sym_valid;
    logic [1:0] rate_sel;
    logic       sync_clr;
    logic       ser_ready;
    logic       ser_out;
    logic       ser_valid;
    logic [3:0] fifo_level;
    logic       ovf;

    int   passed = 0;
    int   total  = 0;
    logic exp_q[$];
    logic phase_m = 1'b0;
    logic hold_m  = 1'b0;
    logic prev_out = 1'b0;
    logic bit_exp;

    always #5 clk = ~clk;

    rsc_punct_ser #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .rate_sel   (rate_sel),
        .sync_clr   (sync_clr),
        .ser_ready  (ser_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .fifo_level (fifo_level),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one symbol for one edge; when it is expected to be accepted, queue its kept bits.
    task automatic send(input logic [3:0] s, input bit accept);
        logic [3:0] m;
        sym_in    = s;
        sym_valid = 1'b1;
        if (accept) begin
            case (rate_sel)
                2'd1:    m = 4'b1011;
                2'd2:    m = phase_m ? 4'b1001 : 4'b0011;
                default: m = 4'b1111;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (m[i]) exp_q.push_back(s[i]);
            end
            phase_m = ~phase_m;
        end
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
        chk("idle_after_drain", 32'(ser_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (hold_m) begin
                chk("hold_valid", 32'(ser_valid), 32'd1);
                chk("hold_out", 32'(ser_out), 32'(prev_out));
            end
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(ser_valid), 32'd0);
                end else begin
                    bit_exp = exp_q.pop_front();
                    chk("bit", 32'(ser_out), 32'(bit_exp));
                end
            end
            hold_m   = ser_valid && !ser_ready;
            prev_out = ser_out;
        end else begin
            hold_m = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        sym_in    = 4'h0;
        sym_valid = 1'b0;
        rate_sel  = 2'd0;
        sync_clr  = 1'b0;
        ser_ready = 1'b1;

        // Reset held with symbols toggling: everything stays at zero.
        for (int k = 0; k < 4; k++) begin
            sym_in    = 4'hF;
            sym_valid = (k % 2 == 0);
            tick();
            chk("rst_valid", 32'(ser_valid), 32'd0);
            chk("rst_out", 32'(ser_out), 32'd0);
            chk("rst_level", 32'(fifo_level), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end
        sym_valid = 1'b0;
        reset     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_valid", 32'(ser_valid), 32'd0);
            chk("post_rst_level", 32'(fifo_level), 32'd0);
        end

        // Rate 1/4, single symbol: four bits after edges N+1..N+4, idle after N+5.
        rate_sel = 2'd0;
        send(4'b1011, 1'b1);
        sym_valid = 1'b0;
        chk("r14_lat_n", 32'(ser_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("r14_valid", 32'(ser_valid), 32'd1);
        end
        tick();
        chk("r14_end", 32'(ser_valid), 32'd0);
        wait_drain(10);

        // Rate 1/3, two back-to-back symbols: six bits with no gap.
        rate_sel = 2'd1;
        send(4'b1111, 1'b1);
        chk("r13_lat_n", 32'(ser_valid), 32'd0);
        send(4'b0100, 1'b1);
        sym_valid = 1'b0;
        chk("r13_valid", 32'(ser_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("r13_gapless", 32'(ser_valid), 32'd1);
        end
        tick();
        chk("r13_end", 32'(ser_valid), 32'd0);
        wait_drain(10);

        // Rate 1/2 after sync_clr: par1/par2 alternate, ready toggling stretches bits.
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        phase_m  = 1'b0;
        rate_sel = 2'd2;
        send(4'b1010, 1'b1);
        send(4'b1010, 1'b1);
        send(4'b0101, 1'b1);
        sym_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ser_ready = ~ser_ready;
            tick();
        end
        ser_ready = 1'b1;
        wait_drain(40);

        // Overflow: nine symbols fit (eight queued + one in the shifter), tenth is dropped.
        rate_sel  = 2'd0;
        ser_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(4'(i * 3 + 1), i < 9);
            if (i == 8) begin
                chk("ovf_level_full", 32'(fifo_level), 32'd8);
                chk("ovf_not_yet", 32'(ovf), 32'd0);
            end
        end
        sym_valid = 1'b0;
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_set", 32'(ovf), 32'd1);
        tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_level_kept", 32'(fifo_level), 32'd8);
        ser_ready = 1'b1;
        wait_drain(60);
        chk("ovf_level_empty", 32'(fifo_level), 32'd0);

        // One more symbol so the phase bit is 1 going into the reset step.
        send(4'b0110, 1'b1);
        sym_valid = 1'b0;
        wait_drain(10);

        // Reset in the middle of a rate-1/4 symbol with three more queued.
        ser_ready = 1'b0;
        send(4'b1111, 1'b1);
        send(4'b1010, 1'b1);
        send(4'b1100, 1'b1);
        send(4'b0011, 1'b1);
        sym_valid = 1'b0;
        chk("mid_queued", 32'(fifo_level), 32'd3);
        ser_ready = 1'b1;
        tick();
        chk("mid_bit1_valid", 32'(ser_valid), 32'd1);
        chk("mid_bit1_out", 32'(ser_out), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(ser_valid), 32'd0);
        chk("async_out", 32'(ser_out), 32'd0);
        chk("async_level", 32'(fifo_level), 32'd0);
        chk("async_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        phase_m = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rel_level", 32'(fifo_level), 32'd0);
        chk("rel_valid", 32'(ser_valid), 32'd0);
        rate_sel = 2'd2;
        send(4'b0110, 1'b1);
        sym_valid = 1'b0;
        wait_drain(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
